// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/DM requester, SRAM and stall signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;

  logic          dm_req;
  logic          dm_we;
  logic [3:0]    dm_sel;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;

  logic          flush;

  logic          ram_en;
  logic          ram_we;
  logic [3:0]    ram_sel;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          stall_req;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_sel, dm_addr, dm_wdata, flush, ram_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
    output ram_en, ram_we, ram_sel, ram_addr, ram_wdata, stall_req
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_sel, dm_addr, dm_wdata, flush, ram_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
    input  ram_en, ram_we, ram_sel, ram_addr, ram_wdata, stall_req
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fixed-priority (DM over IF) arbiter for one fixed-latency SRAM port
module mem_port_arbiter #(
  parameter int LAT = 1,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  if (LAT < 1 || LAT > 15) begin : g_lat_check
    $error("mem_port_arbiter: LAT must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t        state_q;
  owner_t        owner_q;
  logic [3:0]    cnt_q;
  logic          flush_pend_q;
  logic          wr_q;
  logic          ram_en_q;
  logic          ram_we_q;
  logic [3:0]    ram_sel_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wdata_q;
  logic          if_ready_q;
  logic          dm_ready_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;
  logic          if_ready_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_NONE;
      cnt_q        <= 4'd0;
      flush_pend_q <= 1'b0;
      wr_q         <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_sel_q    <= 4'd0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      ram_we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          flush_pend_q <= 1'b0;
          if (bus.dm_req) begin
            owner_q     <= OWN_DM;
            wr_q        <= bus.dm_we;
            ram_en_q    <= 1'b1;
            ram_we_q    <= bus.dm_we;
            ram_sel_q   <= bus.dm_we ? bus.dm_sel : 4'hF;
            ram_addr_q  <= bus.dm_addr;
            ram_wdata_q <= bus.dm_wdata;
            cnt_q       <= CNT_INIT;
            state_q     <= S_ACCESS;
          end else if (bus.if_req && !bus.flush) begin
            owner_q     <= OWN_IF;
            wr_q        <= 1'b0;
            ram_en_q    <= 1'b1;
            ram_sel_q   <= 4'hF;
            ram_addr_q  <= bus.if_addr;
            ram_wdata_q <= '0;
            cnt_q       <= CNT_INIT;
            state_q     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (owner_q == OWN_IF && bus.flush) begin
            flush_pend_q <= 1'b1;
          end
          if (cnt_q == 4'd0) begin
            ram_en_q <= 1'b0;
            state_q  <= S_DONE;
            if (owner_q == OWN_DM) begin
              dm_ready_q <= 1'b1;
              dm_rdata_q <= wr_q ? '0 : bus.ram_rdata;
            end else if (!(flush_pend_q || bus.flush)) begin
              // A fetch flushed at any point of its access is completed on the SRAM but never delivered
              if_ready_q <= 1'b1;
              if_rdata_q <= bus.ram_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          flush_pend_q <= 1'b0;
          owner_q      <= OWN_NONE;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A flush landing on the completion cycle itself still cancels the fetch pulse
  assign if_ready_w    = if_ready_q & ~bus.flush;

  assign bus.if_ready  = if_ready_w;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_sel   = ram_sel_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.stall_req = (bus.if_req & ~if_ready_w & ~bus.flush) | (bus.dm_req & ~dm_ready_q);

endmodule
